// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration register file:
// FSM state encoding, reserved addresses and a frame field-extract helper.
package spi_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  localparam int unsigned ADDR_NOP        = 0;
  localparam int unsigned COMMIT_ADDR_DEF = 15;

  // Widest frame the field helper can handle.
  localparam int unsigned FIELD_MAX_W = 64;

  // Return 'width' bits of 'frame' starting at bit 'lsb', zero-extended.
  function automatic logic [FIELD_MAX_W-1:0] frame_field(
    input logic [FIELD_MAX_W-1:0] frame,
    input int unsigned            lsb,
    input int unsigned            width
  );
    logic [FIELD_MAX_W-1:0] mask;
    mask = '1;
    mask = ~(mask << width);
    return (frame >> lsb) & mask;
  endfunction

endpackage

// File: rtl/spi_cfg_sync.sv
// Multi-stage synchroniser with rise/fall edge detection on the final stage.
module spi_cfg_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Synchroniser chain plus one delay flop for edge comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= RST_VAL ? '1 : '0;
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~dly_q;
  assign fall = ~dout & dly_q;

endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI configuration receiver: oversamples spck/mosi/ncs in the pck0 domain,
// decodes fixed-length frames into a shadow bank and commits it atomically
// to the active bank. Optional readback on miso is enabled by defining
// SPI_CFG_REGFILE_READBACK_EN.
module spi_cfg_regfile
  import spi_cfg_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned FRAME_W     = 16,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned COMMIT_ADDR = COMMIT_ADDR_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       pck0,
  input  logic                       nreset,
  input  logic                       spck,
  input  logic                       mosi,
  input  logic                       ncs,
  output logic                       miso,
  output logic [NUM_REGS*DATA_W-1:0] cfg_active,
  output logic                       cfg_upd,
  output logic                       frame_err
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

  logic spck_rise, spck_fall, mosi_s, ncs_rise, ncs_fall;
  logic unused_spck_lvl, unused_ncs_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_cfg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_spck (
    .clk(pck0), .rst_n(nreset), .din(spck),
    .dout(unused_spck_lvl), .rise(spck_rise), .fall(spck_fall)
  );

  spi_cfg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(pck0), .rst_n(nreset), .din(mosi),
    .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  spi_cfg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(pck0), .rst_n(nreset), .din(ncs),
    .dout(unused_ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic               wr_en, commit, err_d;

  logic [DATA_W-1:0]  shadow_q [NUM_REGS];
  logic [DATA_W-1:0]  active_q [NUM_REGS];

  assign frame_addr = ADDR_W'(frame_field(FIELD_MAX_W'(shreg_q), FRAME_W - ADDR_W, ADDR_W));
  assign frame_data = DATA_W'(frame_field(FIELD_MAX_W'(shreg_q), 0, DATA_W));

  // FSM state, bit counter and shift register.
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state, shifting and frame decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      ST_SHIFT: begin
        // A same-cycle spck rise is shifted before DECODE inspects the count.
        if (spck_rise) begin
          shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        if (ncs_rise) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cnt_q != CNT_FULL)                          err_d  = 1'b1;
        else if (frame_addr == ADDR_W'(ADDR_NOP))       ;
        else if (frame_addr <= ADDR_W'(NUM_REGS))       wr_en  = 1'b1;
        else if (frame_addr == ADDR_W'(COMMIT_ADDR))    commit = 1'b1;
        else                                            err_d  = 1'b1;
        if (ncs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow writes, atomic commit to the active bank, status pulses.
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      cfg_upd   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cfg_upd   <= commit;
      frame_err <= err_d;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (wr_en && frame_addr == ADDR_W'(k + 1)) shadow_q[k] <= frame_data;
        if (commit) active_q[k] <= shadow_q[k];
      end
    end
  end

  // Flatten the active bank onto the output bus.
  always_comb begin
    cfg_active = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      cfg_active[k*DATA_W +: DATA_W] = active_q[k];
    end
  end

`ifdef SPI_CFG_REGFILE_READBACK_EN
  logic               rb_valid_q, rb_valid_d;
  logic [ADDR_W-1:0]  rb_addr_q, rb_addr_d;
  logic [DATA_W-1:0]  rb_data;
  logic [FRAME_W-1:0] rb_frame, rb_sh_q;
  logic               rb_load, miso_q;

  // Track the last valid write; DECODE of any other frame clears it. Using
  // the next-value lets a back-to-back frame see the just-decoded result.
  always_comb begin
    rb_valid_d = rb_valid_q;
    rb_addr_d  = rb_addr_q;
    if (state_q == ST_DECODE) begin
      rb_valid_d = wr_en;
      if (wr_en) rb_addr_d = frame_addr;
    end
    rb_data = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (rb_valid_d && rb_addr_d == ADDR_W'(k + 1)) rb_data = active_q[k];
    end
    rb_frame = '0;
    rb_frame[FRAME_W-1 -: DATA_W] = rb_data;
    rb_load = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
  end

  // Readback shifter: first bit on frame start, then one bit per spck fall.
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      rb_valid_q <= 1'b0;
      rb_addr_q  <= '0;
      rb_sh_q    <= '0;
      miso_q     <= 1'b0;
    end else begin
      rb_valid_q <= rb_valid_d;
      rb_addr_q  <= rb_addr_d;
      if (rb_load) begin
        miso_q  <= rb_frame[FRAME_W-1];
        rb_sh_q <= rb_frame << 1;
      end else if (state_q == ST_SHIFT) begin
        if (spck_fall) begin
          miso_q  <= rb_sh_q[FRAME_W-1];
          rb_sh_q <= rb_sh_q << 1;
        end
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  assign miso = miso_q;
`else
  logic unused_spck_fall;
  assign unused_spck_fall = spck_fall;
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Self-checking bench for spi_cfg_regfile: drives SPI frames bit-by-bit and
// compares against a register-level model of the frame rules.
module tb_spi_cfg_regfile;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int FRAME_W  = 16;
  localparam int NUM_REGS = 4;
  localparam int COMMIT   = 15;
  localparam int SYNC     = 2;
  localparam int H        = 8;   // pck0 cycles per spck half period
`ifdef SPI_CFG_REGFILE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        pck0 = 1'b0;
  logic        nreset = 1'b0;
  logic        spck = 1'b0;
  logic        mosi = 1'b0;
  logic        ncs = 1'b1;
  logic        miso;
  logic [31:0] cfg_active;
  logic        cfg_upd;
  logic        frame_err;

  int errors = 0;
  int checks = 0;

  spi_cfg_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_W(FRAME_W),
    .NUM_REGS(NUM_REGS), .COMMIT_ADDR(COMMIT), .SYNC_STAGES(SYNC)
  ) dut (
    .pck0(pck0), .nreset(nreset), .spck(spck), .mosi(mosi), .ncs(ncs),
    .miso(miso), .cfg_active(cfg_active), .cfg_upd(cfg_upd), .frame_err(frame_err)
  );

  always #5 pck0 = ~pck0;

  // Cycle counter and pulse monitors.
  int cyc = 0;
  int upd_cnt = 0, err_cnt = 0, last_upd_cyc = 0, last_err_cyc = 0, rise_cyc = 0;
  always @(posedge pck0) cyc++;
  always @(negedge pck0) begin
    if (nreset) begin
      if (cfg_upd)   begin upd_cnt++; last_upd_cyc = cyc; end
      if (frame_err) begin err_cnt++; last_err_cyc = cyc; end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Reference model: register banks and readback pointer.
  logic [7:0] shadow_m [NUM_REGS];
  logic [7:0] active_m [NUM_REGS];
  bit         rb_valid_m = 1'b0;
  int         rb_idx_m = 0;
  int         exp_upd = 0, exp_err = 0;

  function automatic logic [31:0] active_packed();
    logic [31:0] p;
    for (int k = 0; k < NUM_REGS; k++) p[k*8 +: 8] = active_m[k];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) begin shadow_m[k] = 8'h00; active_m[k] = 8'h00; end
    rb_valid_m = 1'b0;
  endtask

  task automatic model_frame(input int nbits, input logic [31:0] value);
    int a;
    a = int'(value[15:12]);
    if (nbits != FRAME_W) begin exp_err++; rb_valid_m = 1'b0; end
    else if (a == 0) rb_valid_m = 1'b0;
    else if (a <= NUM_REGS) begin shadow_m[a-1] = value[7:0]; rb_valid_m = 1'b1; rb_idx_m = a - 1; end
    else if (a == COMMIT) begin
      for (int k = 0; k < NUM_REGS; k++) active_m[k] = shadow_m[k];
      exp_upd++; rb_valid_m = 1'b0;
    end else begin exp_err++; rb_valid_m = 1'b0; end
  endtask

  // Send one frame MSB first; capture miso just before each spck fall.
  task automatic spi_frame(input int nbits, input logic [31:0] value, input int gap,
                           output logic [31:0] cap, output logic [31:0] exp_cap);
    logic [15:0] rbw;
    rbw = (RB && rb_valid_m) ? {active_m[rb_idx_m], 8'h00} : 16'h0000;
    exp_cap = '0;
    for (int i = 0; i < nbits; i++) exp_cap = {exp_cap[30:0], (i < 16) ? rbw[15-i] : 1'b0};
    cap = '0;
    ncs = 1'b0; spck = 1'b0;
    repeat (H) @(negedge pck0);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = value[i];
      repeat (H) @(negedge pck0);
      spck = 1'b1;
      repeat (H) @(negedge pck0);
      cap = {cap[30:0], miso};
      spck = 1'b0;
    end
    repeat (H) @(negedge pck0);
    ncs = 1'b1;
    rise_cyc = cyc;
    model_frame(nbits, value);
    repeat (gap) @(negedge pck0);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge pck0);
    checks++; if (cfg_active !== 32'h0) begin errors++; $display("FAIL reset_active got=%h exp=%h", cfg_active, 32'h0); end
    checks++; if (cfg_upd !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b exp=0", cfg_upd); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    model_reset();
    nreset = 1'b1;
    repeat (4) @(negedge pck0);
  endtask

  task automatic test_write_commit();
    logic [31:0] cap, ec;
    int u0;
    spi_frame(16, 32'h10A5, 12, cap, ec);
    checks++; if (cfg_active !== 32'h0) begin errors++; $display("FAIL wc_precommit got=%h exp=%h", cfg_active, 32'h0); end
    u0 = upd_cnt;
    spi_frame(16, 32'hF000, 12, cap, ec);
    checks++; if (cfg_active !== 32'h000000A5) begin errors++; $display("FAIL wc_active got=%h exp=%h", cfg_active, 32'hA5); end
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL wc_upd_pulses got=%0d exp=1", upd_cnt - u0); end
    checks++; if (last_upd_cyc - rise_cyc !== SYNC + 2) begin errors++; $display("FAIL wc_latency got=%0d exp=%0d", last_upd_cyc - rise_cyc, SYNC + 2); end
  endtask

  task automatic test_no_commit();
    logic [31:0] cap, ec, a0;
    int u0;
    u0 = upd_cnt; a0 = cfg_active;
    spi_frame(16, 32'h203C, 12, cap, ec);
    repeat (1000) @(negedge pck0);
    checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL nc_upd got=%0d exp=%0d", upd_cnt, u0); end
    checks++; if (cfg_active !== a0) begin errors++; $display("FAIL nc_active got=%h exp=%h", cfg_active, a0); end
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL nc_err got=%0d exp=%0d", err_cnt, exp_err); end
  endtask

  task automatic test_bad_length();
    logic [31:0] cap, ec;
    int e0;
    e0 = err_cnt;
    spi_frame(15, 32'h0800 | ($urandom & 32'h00FF), 12, cap, ec);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL len15_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (last_err_cyc - rise_cyc !== SYNC + 2) begin errors++; $display("FAIL len15_latency got=%0d exp=%0d", last_err_cyc - rise_cyc, SYNC + 2); end
    spi_frame(17, 32'h02000 | ($urandom & 32'h00FF), 12, cap, ec);
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL len17_err got=%0d exp=2", err_cnt - e0); end
    checks++; if (cfg_active !== active_packed()) begin errors++; $display("FAIL len_active got=%h exp=%h", cfg_active, active_packed()); end
    spi_frame(16, 32'hF000, 12, cap, ec);
    checks++; if (cfg_active !== 32'h00003CA5) begin errors++; $display("FAIL len_shadow got=%h exp=%h", cfg_active, 32'h3CA5); end
  endtask

  task automatic test_bad_addr();
    logic [31:0] cap, ec, a0;
    int e0, u0;
    repeat (5) begin
      spck = 1'b1; repeat (H) @(negedge pck0);
      spck = 1'b0; repeat (H) @(negedge pck0);
    end
    e0 = err_cnt; u0 = upd_cnt; a0 = cfg_active;
    spi_frame(16, 32'h7000 | ($urandom & 32'h0FFF), 12, cap, ec);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL addr7_err got=%0d exp=1", err_cnt - e0); end
    spi_frame(16, 32'h0055, 12, cap, ec);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL nop_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL nop_upd got=%0d exp=%0d", upd_cnt, u0); end
    checks++; if (cfg_active !== a0) begin errors++; $display("FAIL nop_active got=%h exp=%h", cfg_active, a0); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] cap, ec;
    ncs = 1'b0; spck = 1'b0;
    repeat (H) @(negedge pck0);
    for (int i = 0; i < 8; i++) begin
      mosi = 1'b1;
      repeat (H) @(negedge pck0);
      spck = 1'b1;
      repeat (H) @(negedge pck0);
      spck = 1'b0;
    end
    nreset = 1'b0; ncs = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge pck0);
    checks++; if (cfg_active !== 32'h0) begin errors++; $display("FAIL mid_reset_active got=%h exp=0", cfg_active); end
    model_reset();
    nreset = 1'b1;
    repeat (4) @(negedge pck0);
    spi_frame(16, 32'h1055, 12, cap, ec);
    spi_frame(16, 32'hF000, 12, cap, ec);
    checks++; if (cfg_active !== 32'h00000055) begin errors++; $display("FAIL mid_active got=%h exp=%h", cfg_active, 32'h55); end
  endtask

  task automatic test_readback();
    logic [31:0] cap, ec;
    spi_frame(16, 32'h10A5, 12, cap, ec);
    spi_frame(16, 32'hF000, 12, cap, ec);
    spi_frame(16, 32'h10A5, 12, cap, ec);
    checks++; if (cap !== ec) begin errors++; $display("FAIL rb_write got=%h exp=%h", cap, ec); end
    spi_frame(16, 32'h0000, 12, cap, ec);
    checks++; if (cap !== (RB ? 32'hA500 : 32'h0)) begin errors++; $display("FAIL rb_nop got=%h exp=%h", cap, RB ? 32'hA500 : 32'h0); end
    spi_frame(16, 32'h0000, 12, cap, ec);
    checks++; if (cap !== 32'h0) begin errors++; $display("FAIL rb_after_nop got=%h exp=0", cap); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap, ec;
    spi_frame(16, {16'h0, 8'h30, 8'($urandom_range(0, 255))}, 1, cap, ec);
    spi_frame(16, 32'hF000, 12, cap, ec);
    checks++; if (cap !== ec) begin errors++; $display("FAIL b2b_miso got=%h exp=%h", cap, ec); end
    checks++; if (cfg_active !== active_packed()) begin errors++; $display("FAIL b2b_active got=%h exp=%h", cfg_active, active_packed()); end
    checks++; if (upd_cnt !== exp_upd) begin errors++; $display("FAIL b2b_upd got=%0d exp=%0d", upd_cnt, exp_upd); end
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL b2b_err got=%0d exp=%0d", err_cnt, exp_err); end
  endtask

  task automatic test_random();
    logic [31:0] cap, ec, v;
    logic [3:0]  a;
    int nb;
    for (int n = 0; n < 40; n++) begin
      nb = 16;
      case ($urandom_range(0, 5))
        0, 1: begin a = 4'($urandom_range(1, NUM_REGS)); v = {16'h0, a, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))}; end
        2:    v = 32'hF000 | ($urandom & 32'h0FFF);
        3:    v = $urandom & 32'h0FFF;
        4:    begin a = 4'($urandom_range(NUM_REGS + 1, 14)); v = {16'h0, a, 12'($urandom_range(0, 4095))}; end
        default: begin nb = $urandom_range(0, 1) ? 15 : 17; v = $urandom; end
      endcase
      spi_frame(nb, v, 12, cap, ec);
      checks++; if (cfg_active !== active_packed()) begin errors++; $display("FAIL rnd_active[%0d] got=%h exp=%h", n, cfg_active, active_packed()); end
      checks++; if (upd_cnt !== exp_upd) begin errors++; $display("FAIL rnd_upd[%0d] got=%0d exp=%0d", n, upd_cnt, exp_upd); end
      checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL rnd_err[%0d] got=%0d exp=%0d", n, err_cnt, exp_err); end
      checks++; if (cap !== ec) begin errors++; $display("FAIL rnd_miso[%0d] got=%h exp=%h", n, cap, ec); end
    end
  endtask

  initial begin
    model_reset();
    @(negedge pck0);
    test_reset();
    test_write_commit();
    test_no_commit();
    test_bad_length();
    test_bad_addr();
    test_reset_midframe();
    test_readback();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
